// File: rtl/axi_image_streamer.sv
// axi_image_streamer: reads one frame of gray pixels from single-port BRAM and
// emits it as an AXI4-Stream of RGB beats (gray byte replicated into {g,g,g}).
// A 4-entry output FIFO absorbs read latency so backpressure never loses beats.
`timescale 1ns/1ps
module axi_image_streamer #(
  parameter int unsigned pixel_per_clk = 8,
  parameter int unsigned addr_width    = 14,
  parameter int unsigned line_beats    = 80,
  parameter int unsigned frame_lines   = 200
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         bram_en,
  output logic [addr_width-1:0]        bram_addr,
  input  logic [8*pixel_per_clk-1:0]   bram_data_in,
  output logic                         M_TVALID,
  input  logic                         M_TREADY,
  output logic [24*pixel_per_clk-1:0]  M_TDATA,
  output logic [3*pixel_per_clk-1:0]   M_TKEEP,
  output logic [3*pixel_per_clk-1:0]   M_TSTRB,
  output logic                         M_TLAST,
  output logic                         M_TUSER
);

  localparam int unsigned DataW      = 8 * pixel_per_clk;
  localparam int unsigned BeatW      = (line_beats > 1) ? $clog2(line_beats) : 1;
  localparam int unsigned LineW      = (frame_lines > 1) ? $clog2(frame_lines) : 1;
  localparam longint unsigned FrameBeats = longint'(line_beats) * longint'(frame_lines);

  if (FrameBeats > (longint'(1) << addr_width)) begin : g_size_check
    $error("frame does not fit in the BRAM address space");
  end

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e state_q, state_d;

  // Read side
  logic [addr_width-1:0] addr_q;
  logic                  rd_pend_q;
  logic [BeatW-1:0]      beat_q;
  logic [LineW-1:0]      line_q;
  logic                  rd_issue;

  // Sideband pipe alongside the BRAM read latency
  logic                  inflight_q;
  logic                  pipe_tuser_q;
  logic                  pipe_tlast_q;

  // Output FIFO
  logic [DataW-1:0]      data_mem_q  [4];
  logic                  tuser_mem_q [4];
  logic                  tlast_mem_q [4];
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic [2:0]            fifo_count_q;
  logic [2:0]            fifo_count_d;
  logic [DataW-1:0]      head_data;
  logic                  head_tuser;
  logic                  head_tlast;
  logic                  hs;

  // Output side
  logic [LineW-1:0]      out_line_q;
  logic                  frame_end;
  logic                  done_q;

  assign head_data  = data_mem_q[rd_ptr_q];
  assign head_tuser = tuser_mem_q[rd_ptr_q];
  assign head_tlast = tlast_mem_q[rd_ptr_q];
  assign hs         = (fifo_count_q != 3'd0) && M_TREADY;

  // Counting in-flight reads against the FIFO guarantees a landing slot.
  assign rd_issue = (state_q == StStream) && rd_pend_q &&
                    (({1'b0, fifo_count_q} + {3'b000, inflight_q}) <= 4'd2);

  assign frame_end = (state_q == StStream) && hs && head_tlast &&
                     (out_line_q == LineW'(frame_lines - 1));

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next state: start only honoured when idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StStream;
      StStream: if (frame_end) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q == StStream);
    done      = done_q;
    bram_en   = rd_issue;
    bram_addr = addr_q;
    M_TVALID  = (fifo_count_q != 3'd0);
  end

  // Read address and beat/line counters
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
      beat_q    <= '0;
      line_q    <= '0;
    end else if (state_q == StIdle) begin
      if (start) begin
        addr_q    <= '0;
        rd_pend_q <= 1'b1;
        beat_q    <= '0;
        line_q    <= '0;
      end
    end else if (rd_issue) begin
      if (longint'(addr_q) == FrameBeats - 1) begin
        addr_q    <= '0;
        rd_pend_q <= 1'b0;
      end else begin
        addr_q <= addr_q + 1'b1;
      end
      if (beat_q == BeatW'(line_beats - 1)) begin
        beat_q <= '0;
        line_q <= line_q + 1'b1;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Sideband pipe: flags follow their read by one cycle
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      inflight_q   <= 1'b0;
      pipe_tuser_q <= 1'b0;
      pipe_tlast_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      if (rd_issue) begin
        pipe_tuser_q <= (addr_q == '0);
        pipe_tlast_q <= (beat_q == BeatW'(line_beats - 1));
      end
    end
  end

  always_comb begin
    fifo_count_d = fifo_count_q + {2'b00, inflight_q} - {2'b00, hs};
  end

  // Output FIFO: written as read data lands, popped on handshake
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < 4; i++) begin
        data_mem_q[i]  <= '0;
        tuser_mem_q[i] <= 1'b0;
        tlast_mem_q[i] <= 1'b0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (inflight_q) begin
        data_mem_q[wr_ptr_q]  <= bram_data_in;
        tuser_mem_q[wr_ptr_q] <= pipe_tuser_q;
        tlast_mem_q[wr_ptr_q] <= pipe_tlast_q;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (hs) rd_ptr_q <= rd_ptr_q + 1'b1;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Output line tracking and the done pulse
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      out_line_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (state_q == StIdle) begin
        if (start) out_line_q <= '0;
      end else if (hs && head_tlast) begin
        out_line_q <= out_line_q + 1'b1;
      end
    end
  end

  // RGB expansion of the registered FIFO head
  always_comb begin
    M_TDATA = '0;
    for (int p = 0; p < int'(pixel_per_clk); p++) begin
      M_TDATA[24*p +: 24] = {3{head_data[8*p +: 8]}};
    end
    M_TUSER = head_tuser;
    M_TLAST = head_tlast;
    M_TKEEP = '1;
    M_TSTRB = '1;
  end

  fifo_bound: assert property (@(posedge ACLK) disable iff (!ARESETn) fifo_count_q <= 3'd4);

endmodule

// File: tb/tb_axi_image_streamer.sv
// Directed bench for axi_image_streamer on a small 4x3-beat frame.
`timescale 1ns/1ps
module tb_axi_image_streamer;

  localparam int unsigned Ppc = 8;
  localparam int unsigned Aw  = 14;
  localparam int unsigned Lb  = 4;
  localparam int unsigned Fl  = 3;
  localparam int          Nb  = 12;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, bram_en;
  logic [Aw-1:0]    bram_addr;
  logic [63:0]      bram_data_in = '0;
  logic             M_TVALID;
  logic             M_TREADY = 1'b0;
  logic [191:0]     M_TDATA;
  logic [23:0]      M_TKEEP, M_TSTRB;
  logic             M_TLAST, M_TUSER;

  axi_image_streamer #(
    .pixel_per_clk(Ppc), .addr_width(Aw), .line_beats(Lb), .frame_lines(Fl)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .busy(busy), .done(done),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_data_in(bram_data_in),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TKEEP(M_TKEEP),
    .M_TSTRB(M_TSTRB), .M_TLAST(M_TLAST), .M_TUSER(M_TUSER)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int   addr;   // BRAM word that must feed this beat
    logic tuser;
    logic tlast;
  } vec_t;

  vec_t exp_tab[Nb];

  int   checks = 0;
  int   errors = 0;
  logic alt_word0 = 1'b0;
  int   tr_mode = 0;     // 0: ready high, 1: random, 2: ready low
  int   beat_idx = 0;
  int   cyc = 0;
  int   rd_count = 0;
  int   first_hs_cyc = 0;
  int   last_hs_cyc = 0;
  logic [191:0] first_tdata = '0;
  logic         prev_stall = 1'b0;
  logic [191:0] prev_data = '0;
  logic         prev_user = 1'b0;
  logic         prev_last = 1'b0;

  function automatic logic [63:0] word_of(input int k);
    if (k == 0 && alt_word0) return 64'h0706050403020100;
    return 64'(k) * 64'h0101010101010101;
  endfunction

  function automatic logic [191:0] expand(input logic [63:0] w);
    logic [191:0] r;
    for (int p = 0; p < 8; p++) r[24*p +: 24] = {w[8*p +: 8], w[8*p +: 8], w[8*p +: 8]};
    return r;
  endfunction

  // Single-port BRAM model, one-cycle read latency
  always @(posedge ACLK) if (bram_en) bram_data_in <= word_of(int'(bram_addr));

  // Ready pattern, changed just after each rising edge
  always begin
    @(posedge ACLK);
    #1;
    case (tr_mode)
      0:       M_TREADY = 1'b1;
      1:       M_TREADY = 1'($urandom_range(0, 1));
      default: M_TREADY = 1'b0;
    endcase
  end

  // Stream monitor: scores every handshake and checks payload stability while stalled
  always @(negedge ACLK) begin
    cyc++;
    if (ARESETn && bram_en) rd_count++;
    if (ARESETn && prev_stall) begin
      checks++;
      if (M_TVALID !== 1'b1 || M_TDATA !== prev_data || M_TUSER !== prev_user ||
          M_TLAST !== prev_last) begin
        errors++;
        $display("FAIL stall_stable valid=%b data=%h want=%h", M_TVALID, M_TDATA, prev_data);
      end
    end
    prev_stall = ARESETn && M_TVALID && !M_TREADY;
    prev_data  = M_TDATA;
    prev_user  = M_TUSER;
    prev_last  = M_TLAST;
    if (ARESETn && M_TVALID && M_TREADY) begin
      checks++;
      if (beat_idx >= Nb) begin
        errors++;
        $display("FAIL extra_beat got beat %0d required at most %0d", beat_idx, Nb - 1);
      end else begin
        if (M_TUSER !== exp_tab[beat_idx].tuser || M_TLAST !== exp_tab[beat_idx].tlast ||
            M_TDATA !== expand(word_of(exp_tab[beat_idx].addr))) begin
          errors++;
          $display("FAIL beat%0d got user=%b last=%b data=%h required user=%b last=%b data=%h",
                   beat_idx, M_TUSER, M_TLAST, M_TDATA, exp_tab[beat_idx].tuser,
                   exp_tab[beat_idx].tlast, expand(word_of(exp_tab[beat_idx].addr)));
        end
        if (beat_idx == 0) begin
          first_hs_cyc = cyc;
          first_tdata  = M_TDATA;
        end
        last_hs_cyc = cyc;
      end
      beat_idx++;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic pulse_start();
    beat_idx = 0;
    rd_count = 0;
    start = 1'b1;
    tick();               // edge E0 samples start
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input bit check_timing, input bit extra_starts);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 2000) begin
      start = extra_starts && (n == 5 || n == 13);
      tick();
      n++;
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    if (check_timing) chk("start_to_done_edges", n, 14);
    chk("beats_in_frame", beat_idx, Nb);
    chk("busy_low_with_done", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_tab = '{'{0, 1'b1, 1'b0}, '{1, 1'b0, 1'b0}, '{2, 1'b0, 1'b0}, '{3, 1'b0, 1'b1},
                '{4, 1'b0, 1'b0}, '{5, 1'b0, 1'b0}, '{6, 1'b0, 1'b0}, '{7, 1'b0, 1'b1},
                '{8, 1'b0, 1'b0}, '{9, 1'b0, 1'b0}, '{10, 1'b0, 1'b0}, '{11, 1'b0, 1'b1}};

    // Reset values
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_tvalid", M_TVALID, 0);
    chk("rst_tlast", M_TLAST, 0);
    chk("rst_tuser", M_TUSER, 0);
    chk("rst_tdata", M_TDATA, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    tick();

    // Full-rate frame, with extra starts mid-frame and on the last-handshake edge
    tr_mode = 0;
    tick();
    pulse_start();
    wait_done(1, 1);
    repeat (10) tick();
    chk("no_second_frame_busy", busy, 0);
    chk("no_second_frame_valid", M_TVALID, 0);
    chk("no_second_frame_beats", beat_idx, Nb);

    // Random backpressure
    tr_mode = 1;
    pulse_start();
    wait_done(0, 0);
    tr_mode = 0;
    repeat (3) tick();

    // Long stall after first valid
    tr_mode = 2;
    repeat (2) tick();
    pulse_start();
    for (int i = 0; i < 50 && M_TVALID !== 1'b1; i++) tick();
    chk("stall_first_valid", M_TVALID, 1);
    repeat (20) tick();
    chk("stall_reads_le3", (rd_count <= 3), 1);
    chk("stall_reads_nonzero", (rd_count >= 1), 1);
    chk("stall_bram_en_low", bram_en, 0);
    chk("stall_valid_held", M_TVALID, 1);
    chk("stall_head_tuser", M_TUSER, 1);
    chk("stall_no_beats", beat_idx, 0);
    tr_mode = 0;
    wait_done(0, 0);
    chk("release_no_bubble", last_hs_cyc - first_hs_cyc, Nb - 1);
    repeat (3) tick();

    // Pixel lane mapping
    alt_word0 = 1'b1;
    pulse_start();
    wait_done(1, 0);
    for (int p = 0; p < 8; p++) begin
      logic [7:0] g;
      g = 8'(p);
      chk($sformatf("pixel_lane%0d", p), first_tdata[24*p +: 24], {g, g, g});
    end
    chk("tkeep_ones", M_TKEEP, 24'hFFFFFF);
    chk("tstrb_ones", M_TSTRB, 24'hFFFFFF);
    alt_word0 = 1'b0;
    repeat (3) tick();

    // Reset mid-frame at beat 5
    pulse_start();
    for (int i = 0; i < 100 && beat_idx < 5; i++) tick();
    chk("reset_reached_beat5", beat_idx, 5);
    ARESETn = 1'b0;
    #1;
    chk("reset_tvalid_async", M_TVALID, 0);
    chk("reset_busy_async", busy, 0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    begin
      bit any_done = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (done === 1'b1) any_done = 1;
      end
      chk("reset_no_done", any_done, 0);
    end
    chk("reset_idle_busy", busy, 0);
    chk("reset_idle_valid", M_TVALID, 0);
    pulse_start();
    wait_done(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
